// File: rtl/vertex_fetch.sv
// Vertex fetcher: reads a count word, then whole vertex records, over Avalon-MM.
// Define VF_STATS_EN to build the stall-cycle counter behind stat_stall_cycles.
module vertex_fetch #(
  parameter int ADDR_W     = 26,
  parameter int DATA_W     = 32,
  parameter int VERT_WORDS = 3
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         start,
  input  logic [ADDR_W-1:0]            vertex_buffer_base,
  output logic                         busy,
  output logic                         done,
  output logic [ADDR_W-1:0]            avm_address,
  output logic                         avm_read,
  input  logic [DATA_W-1:0]            avm_readdata,
  input  logic                         avm_waitrequest,
  input  logic                         avm_readdatavalid,
  output logic                         vtx_valid,
  input  logic                         vtx_ready,
  output logic [VERT_WORDS*DATA_W-1:0] vtx_data,
  output logic [15:0]                  vtx_index,
  output logic                         vtx_last,
  output logic [31:0]                  stat_stall_cycles
);

  localparam int VB = VERT_WORDS * DATA_W;
  localparam logic [2:0] WLAST = 3'(VERT_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CNT_RD,
    S_CNT_WAIT,
    S_V_RD,
    S_V_WAIT,
    S_EMIT,
    S_DONE
  } state_e;

  state_e            state_q;
  logic              start_q;
  logic              busy_q;
  logic              done_q;
  logic              rd_q;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       remaining_q;
  logic [15:0]       idx_q;
  logic [2:0]        w_q;
  logic [VB-1:0]     words_q;
  logic              valid_q;
  logic              last_q;
  logic              start_edge;

  assign start_edge = start & ~start_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      start_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rd_q        <= 1'b0;
      addr_q      <= '0;
      remaining_q <= '0;
      idx_q       <= '0;
      w_q         <= '0;
      words_q     <= '0;
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
    end else begin
      start_q <= start;
      done_q  <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start_edge) begin
            addr_q  <= vertex_buffer_base;
            busy_q  <= 1'b1;
            rd_q    <= 1'b1;
            state_q <= S_CNT_RD;
          end
        end
        S_CNT_RD: begin
          if (!avm_waitrequest) begin
            rd_q    <= 1'b0;
            state_q <= S_CNT_WAIT;
          end
        end
        S_CNT_WAIT: begin
          if (avm_readdatavalid) begin
            remaining_q <= avm_readdata[15:0];
            idx_q       <= '0;
            w_q         <= '0;
            addr_q      <= addr_q + ADDR_W'(4);
            if (avm_readdata[15:0] == 16'd0) begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= S_DONE;
            end else begin
              rd_q    <= 1'b1;
              state_q <= S_V_RD;
            end
          end
        end
        S_V_RD: begin
          if (!avm_waitrequest) begin
            rd_q    <= 1'b0;
            state_q <= S_V_WAIT;
          end
        end
        S_V_WAIT: begin
          if (avm_readdatavalid) begin
            // shift in from the top so word0 ends up in the LSBs
            words_q <= (words_q >> DATA_W)
                     | (VB'(avm_readdata) << ((VERT_WORDS - 1) * DATA_W));
            addr_q  <= addr_q + ADDR_W'(4);
            if (w_q == WLAST) begin
              w_q     <= '0;
              valid_q <= 1'b1;
              last_q  <= (remaining_q == 16'd1);
              state_q <= S_EMIT;
            end else begin
              w_q     <= w_q + 3'd1;
              rd_q    <= 1'b1;
              state_q <= S_V_RD;
            end
          end
        end
        S_EMIT: begin
          if (vtx_ready) begin
            valid_q     <= 1'b0;
            last_q      <= 1'b0;
            idx_q       <= idx_q + 16'd1;
            remaining_q <= remaining_q - 16'd1;
            if (remaining_q == 16'd1) begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= S_DONE;
            end else begin
              rd_q    <= 1'b1;
              state_q <= S_V_RD;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign avm_read    = rd_q;
  assign avm_address = addr_q;
  assign vtx_valid   = valid_q;
  assign vtx_data    = words_q;
  assign vtx_index   = idx_q;
  assign vtx_last    = last_q;

`ifdef VF_STATS_EN
  logic [31:0] stat_q;
  logic [31:0] stat_d;
  logic        stall;

  assign stall = ((state_q == S_EMIT) && !vtx_ready)
               || (rd_q && avm_waitrequest);

  always_comb begin
    stat_d = stat_q;
    if ((state_q == S_IDLE) && start_edge) begin
      stat_d = '0;
    end else if (stall && (stat_q != '1)) begin
      stat_d = stat_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_q <= '0;
    end else begin
      stat_q <= stat_d;
    end
  end

  assign stat_stall_cycles = stat_q;
`else
  assign stat_stall_cycles = '0;
`endif

endmodule

// File: tb/tb_vertex_fetch.sv
// Randomized bench for vertex_fetch: Avalon slave model, stalling consumer,
// and a reference built from the memory image and pass configuration.
`timescale 1ns/1ps
module tb_vertex_fetch;

  localparam int AW = 26;
  localparam int DW = 32;
  localparam int VW = 3;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              start;
  logic [AW-1:0]     base;
  logic              busy;
  logic              done;
  logic [AW-1:0]     avm_address;
  logic              avm_read;
  logic [DW-1:0]     avm_readdata;
  logic              avm_waitrequest;
  logic              avm_readdatavalid;
  logic              vtx_valid;
  logic              vtx_ready;
  logic [VW*DW-1:0]  vtx_data;
  logic [15:0]       vtx_index;
  logic              vtx_last;
  logic [31:0]       stat_stall_cycles;

  always #5 clk = ~clk;

  vertex_fetch #(.ADDR_W(AW), .DATA_W(DW), .VERT_WORDS(VW)) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .start              (start),
    .vertex_buffer_base (base),
    .busy               (busy),
    .done               (done),
    .avm_address        (avm_address),
    .avm_read           (avm_read),
    .avm_readdata       (avm_readdata),
    .avm_waitrequest    (avm_waitrequest),
    .avm_readdatavalid  (avm_readdatavalid),
    .vtx_valid          (vtx_valid),
    .vtx_ready          (vtx_ready),
    .vtx_data           (vtx_data),
    .vtx_index          (vtx_index),
    .vtx_last           (vtx_last),
    .stat_stall_cycles  (stat_stall_cycles)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag,
                       input logic [127:0] got,
                       input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [31:0]      mem [int];
  int               wait_cfg, lat_cfg, rs_rest, rs_left;
  logic [AW-1:0]    acc_q [$];
  logic [VW*DW-1:0] vd_q [$];
  logic [15:0]      vi_q [$];
  logic             vl_q [$];
  int               done_cnt, stable_err, outst_err, emit_rd_err, hold_err;

  function automatic logic [31:0] rdmem(input logic [AW-1:0] a);
    if (mem.exists(int'(a))) return mem[int'(a)];
    return 32'hDEAD_BEEF;
  endfunction

  // Avalon slave + consumer + bus-rule monitors, all acting on the falling edge
  initial begin : bfm
    bit                in_req = 0;
    bit                pend = 0;
    bit                stalled = 0;
    int                wcnt = 0;
    int                lat = 0;
    logic [AW-1:0]     req_addr = '0;
    logic [AW-1:0]     paddr = '0;
    logic [VW*DW+16:0] sv = '0;
    avm_readdata      = '0;
    avm_readdatavalid = 1'b0;
    avm_waitrequest   = 1'b0;
    vtx_ready         = 1'b0;
    forever begin
      @(negedge clk);
      avm_readdatavalid = 1'b0;
      if (pend) begin
        if (lat == 0) begin
          avm_readdatavalid = 1'b1;
          avm_readdata      = rdmem(paddr);
          pend              = 0;
        end else begin
          lat--;
        end
      end
      if (done) done_cnt++;
      if (avm_read && vtx_valid) emit_rd_err++;
      if (avm_read) begin
        if (pend) outst_err++;
        if (!in_req) begin
          in_req   = 1;
          req_addr = avm_address;
          wcnt     = wait_cfg;
        end else if (avm_address !== req_addr) begin
          stable_err++;
        end
        if (wcnt > 0) begin
          avm_waitrequest = 1'b1;
          wcnt--;
        end else begin
          avm_waitrequest = 1'b0;
          in_req = 0;
          acc_q.push_back(avm_address);
          pend  = 1;
          paddr = avm_address;
          lat   = lat_cfg;
        end
      end else begin
        if (in_req && reset_n) stable_err++;
        in_req = 0;
        avm_waitrequest = 1'($urandom_range(0, 1));
      end
      if (stalled && reset_n &&
          (!vtx_valid || {vtx_data, vtx_index, vtx_last} !== sv))
        hold_err++;
      stalled = 0;
      if (vtx_valid) begin
        if (rs_left > 0) begin
          vtx_ready = 1'b0;
          rs_left--;
          stalled = 1;
          sv = {vtx_data, vtx_index, vtx_last};
        end else begin
          vtx_ready = 1'b1;
          vd_q.push_back(vtx_data);
          vi_q.push_back(vtx_index);
          vl_q.push_back(vtx_last);
          rs_left = rs_rest;
        end
      end else begin
        vtx_ready = 1'($urandom_range(0, 1));
      end
    end
  end

  logic [31:0] words [$];

  task automatic load_mem(input logic [AW-1:0] b, input int n, input bit seq);
    logic [AW-1:0] a;
    logic [31:0]   w;
    mem.delete();
    words.delete();
    mem[int'(b)] = {16'($urandom), 16'(n)};
    for (int i = 0; i < n * VW; i++) begin
      w = seq ? 32'(i + 1) : $urandom;
      words.push_back(w);
      a = b + AW'(4 * (i + 1));
      mem[int'(a)] = w;
    end
  endtask

  task automatic clear_logs(input int wc, input int lc, input int rf, input int rr);
    acc_q.delete();
    vd_q.delete();
    vi_q.delete();
    vl_q.delete();
    done_cnt = 0; stable_err = 0; outst_err = 0;
    emit_rd_err = 0; hold_err = 0;
    wait_cfg = wc; lat_cfg = lc; rs_left = rf; rs_rest = rr;
  endtask

  task automatic run_pass(input logic [AW-1:0] b, input int n,
                          input int wc, input int lc, input int rf, input int rr,
                          input bit seq, input bit hold, input bit poke);
    int               cyc = 0;
    int               busy_err = 0;
    bit               tmo = 0;
    longint           exp_st;
    logic [AW-1:0]    ea;
    logic [VW*DW-1:0] ev;
    load_mem(b, n, seq);
    clear_logs(wc, lc, rf, rr);
    @(posedge clk); #1;
    start = 1'b0;
    base  = b;
    @(posedge clk); #1;
    start = 1'b1;
    while (1) begin
      @(posedge clk); #1;
      if (done) break;
      if (!busy) busy_err++;
      cyc++;
      if (cyc == 1) begin
        base = AW'($urandom);
        if (!hold) start = 1'b0;
      end
      if (poke && cyc == 4) start = 1'b1;
      if (poke && cyc == 5) start = 1'b0;
      if (cyc > 3000) begin
        tmo = 1;
        break;
      end
    end
    check("timeout", tmo, 0);
    check("busy_run", busy_err, 0);
    check("busy_at_done", busy, 0);
    if (wc == 0 && lc == 0 && rf == 0 && rr == 0)
      check("latency", cyc, 2 + 2 * n * VW + n);
    @(posedge clk); #1;
    check("done_pulse", done, 0);
    repeat (8) @(posedge clk);
    #1;
    check("done_cnt", done_cnt, 1);
    check("idle_busy", busy, 0);
    check("nreads", acc_q.size(), 1 + n * VW);
    for (int i = 0; i < acc_q.size() && i < 1 + n * VW; i++) begin
      ea = b + AW'(4 * i);
      check("addr", acc_q[i], ea);
    end
    check("nvtx", vd_q.size(), n);
    for (int j = 0; j < vd_q.size() && j < n; j++) begin
      ev = '0;
      for (int k = 0; k < VW; k++) ev[k*DW +: DW] = words[j*VW + k];
      check("vdata", vd_q[j], ev);
      check("vidx", vi_q[j], j);
      check("vlast", vl_q[j], (j == n - 1));
    end
    check("bus_rules", stable_err + outst_err + emit_rd_err + hold_err, 0);
`ifdef VF_STATS_EN
    exp_st = longint'(1 + n * VW) * wc + ((n > 0) ? (rf + (n - 1) * rr) : 0);
`else
    exp_st = 0;
`endif
    check("stall_cnt", stat_stall_cycles, exp_st);
  endtask

  task automatic reset_mid();
    int cyc = 0;
    load_mem(AW'(32'h300000), 3, 0);
    clear_logs(0, 3, 0, 0);
    @(posedge clk); #1;
    start = 1'b0;
    base  = AW'(32'h300000);
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (acc_q.size() < 3 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("rst_reach", cyc < 200, 1);
    reset_n = 1'b0;
    #1;
    check("rst_ctl", {busy, done, avm_read, vtx_valid, vtx_last}, 0);
    check("rst_bus", {avm_address, vtx_index, stat_stall_cycles}, 0);
    check("rst_data", vtx_data, 0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("post_rst", {busy, done, avm_read, vtx_valid}, 0);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    logic [AW-1:0] rb;
    int            rn;
    reset_n = 1'b0;
    start   = 1'b0;
    base    = '0;
    clear_logs(0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    check("reset_ctl", {busy, done, avm_read, vtx_valid, vtx_last}, 0);
    check("reset_bus", {avm_address, vtx_index, stat_stall_cycles}, 0);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    run_pass(AW'(32'h300000), 0, 0, 0, 0, 0, 1, 0, 0);
    run_pass(AW'(32'h300000), 2, 0, 0, 0, 0, 1, 0, 0);
    run_pass(AW'(32'h300000), 2, 5, 0, 0, 0, 1, 0, 0);
    run_pass(AW'(32'h300000), 2, 0, 0, 10, 0, 1, 0, 0);
    run_pass(AW'(32'h300000), 2, 0, 1, 0, 0, 1, 1, 0);
    run_pass(AW'(32'h300100), 1, 1, 0, 2, 0, 0, 0, 0);
    run_pass(AW'((1 << AW) - 8), 2, 1, 2, 1, 1, 0, 0, 0);
    reset_mid();
    run_pass(AW'(32'h300000), 2, 0, 0, 0, 0, 1, 0, 0);
    for (int t = 0; t < 12; t++) begin
      rb = AW'($urandom);
      rb[1:0] = 2'b00;
      rn = $urandom_range(0, 6);
      run_pass(rb, rn, $urandom_range(0, 3), $urandom_range(0, 3),
               $urandom_range(0, 4), $urandom_range(0, 3), 0, 0,
               (rn > 0) && ($urandom_range(0, 1) == 1));
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
